data_bank_ctrl: RTL and testbench

Sequencing controller for the 4-unit data register bank. It generates the bank's address, data, write-address and write-all strobes. It shares the bank between two sources: a host loader that streams four 32-bit initial values, and a run engine that commits neuron outputs into the bank a programmed number of times, with a fixed settle interval between commits.

---
 rtl/data_bank_pkg.sv | 15 +
 rtl/data_bank_ctrl_if.sv | 33 +++
 rtl/data_bank_ctrl_settle_timer.sv | 31 +++
 rtl/data_bank_ctrl.sv | 141 ++++++++++++++
 tb/tb_data_bank_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bank_pkg.sv
// Shared constants and FSM state encoding for the data bank controller.
package data_bank_pkg;
  localparam int NUM_UNITS = 4;
  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_DONE,
    RUN_WAIT,
    RUN_COMMIT,
    RUN_DONE
  } state_t;
endpackage

// File: rtl/data_bank_ctrl_if.sv
// Host/run-engine control and bank drive bundle; the controller uses the slave view.
interface data_bank_ctrl_if
  import data_bank_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              run_start;
  logic [CNT_W-1:0]  run_count;
  logic              run_abort;
  logic              run_done;
  logic              busy;
  logic [DATA_W-1:0] bank_data;
  logic [ADDR_W-1:0] bank_addr;
  logic              bank_wr_addr;
  logic              bank_wr_all;

  modport master (
    output ld_start, ld_valid, ld_data, run_start, run_count, run_abort,
    input  ld_ready, ld_done, run_done, busy,
    input  bank_data, bank_addr, bank_wr_addr, bank_wr_all
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, run_start, run_count, run_abort,
    output ld_ready, ld_done, run_done, busy,
    output bank_data, bank_addr, bank_wr_addr, bank_wr_all
  );
endinterface

// File: rtl/data_bank_ctrl_settle_timer.sv
// Loadable down-counter; expire_o is high for the single cycle the count sits at 1,
// so a load followed by no further loads expires SETTLE-1 cycles later.
module settle_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expire_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 8'(SETTLE);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 8'd1);
endmodule

// File: rtl/data_bank_ctrl.sv
// Bank sequencer: 4-word host load (1 word/cycle, ld_ready high throughout LOAD) and
// timed parallel commits; all outputs registered. DATA_BANK_CTRL_STATS_EN adds commit_total.
module data_bank_ctrl
  import data_bank_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  data_bank_ctrl_if.slave   bus
`ifdef DATA_BANK_CTRL_STATS_EN
  ,
  output logic [31:0]       commit_total
`endif
);
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  iter_q;
  logic [DATA_W-1:0] bank_data_q;
  logic [ADDR_W-1:0] bank_addr_q;
  logic              bank_wr_addr_q;
  logic              bank_wr_all_q;
  logic              ld_ready_q;
  logic              ld_done_q;
  logic              run_done_q;
  logic              busy_q;
  logic              timer_load;
  logic              timer_expire;

  // Re-arm while idle and during each commit so every RUN_WAIT starts from a full interval.
  assign timer_load = (state_q == IDLE) || (state_q == RUN_COMMIT);

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (timer_load),
    .expire_o (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      iter_q         <= '0;
      bank_data_q    <= '0;
      bank_addr_q    <= '0;
      bank_wr_addr_q <= 1'b0;
      bank_wr_all_q  <= 1'b0;
      ld_ready_q     <= 1'b0;
      ld_done_q      <= 1'b0;
      run_done_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      bank_wr_addr_q <= 1'b0;
      bank_wr_all_q  <= 1'b0;
      ld_done_q      <= 1'b0;
      run_done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ld_start) begin
            state_q    <= LOAD;
            addr_q     <= '0;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (bus.run_start) begin
            iter_q  <= bus.run_count;
            busy_q  <= 1'b1;
            state_q <= (bus.run_count == '0) ? RUN_DONE : RUN_WAIT;
          end
        end
        LOAD: begin
          if (bus.ld_valid && ld_ready_q) begin
            bank_data_q    <= bus.ld_data;
            bank_addr_q    <= addr_q;
            bank_wr_addr_q <= 1'b1;
            addr_q         <= addr_q + 1'b1;
            if (addr_q == ADDR_W'(NUM_UNITS - 1)) begin
              state_q    <= LOAD_DONE;
              ld_ready_q <= 1'b0;
            end
          end
        end
        LOAD_DONE: begin
          ld_done_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        RUN_WAIT: begin
          // Abort beats a coincident expiry: no commit once abort is seen here.
          if (bus.run_abort) begin
            state_q <= RUN_DONE;
          end else if (timer_expire) begin
            state_q <= RUN_COMMIT;
          end
        end
        RUN_COMMIT: begin
          bank_wr_all_q <= 1'b1;
          iter_q        <= iter_q - 1'b1;
          if ((iter_q == CNT_W'(1)) || bus.run_abort) begin
            state_q <= RUN_DONE;
          end else begin
            state_q <= RUN_WAIT;
          end
        end
        RUN_DONE: begin
          run_done_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bank_data    = bank_data_q;
  assign bus.bank_addr    = bank_addr_q;
  assign bus.bank_wr_addr = bank_wr_addr_q;
  assign bus.bank_wr_all  = bank_wr_all_q;
  assign bus.ld_ready     = ld_ready_q;
  assign bus.ld_done      = ld_done_q;
  assign bus.run_done     = run_done_q;
  assign bus.busy         = busy_q;

`ifdef DATA_BANK_CTRL_STATS_EN
  logic [31:0] commit_total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_total_q <= 32'd0;
    end else if (bank_wr_all_q && (commit_total_q != 32'hFFFF_FFFF)) begin
      commit_total_q <= commit_total_q + 32'd1;
    end
  end

  assign commit_total = commit_total_q;
`endif
endmodule

// File: tb/tb_data_bank_ctrl.sv
// Directed self-checking bench for data_bank_ctrl (SETTLE=4, CNT_W=16).
module tb_data_bank_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  data_bank_ctrl_if #(.CNT_W(16)) bus ();

`ifdef DATA_BANK_CTRL_STATS_EN
  logic [31:0] commit_total;
`endif

  data_bank_ctrl #(.SETTLE(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DATA_BANK_CTRL_STATS_EN
    ,
    .commit_total (commit_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_start  = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = 32'd0;
    bus.run_start = 1'b0;
    bus.run_count = 16'd0;
    bus.run_abort = 1'b0;
  endtask

  function automatic logic [39:0] all_outs();
    return {bus.ld_ready, bus.ld_done, bus.run_done, bus.busy, bus.bank_wr_addr,
            bus.bank_wr_all, bus.bank_addr, bus.bank_data};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ld_start  = 1'($urandom);
      bus.ld_valid  = 1'($urandom);
      bus.ld_data   = $urandom;
      bus.run_start = 1'($urandom);
      bus.run_count = 16'($urandom);
      bus.run_abort = 1'($urandom);
      step();
      checks++;
      if (all_outs() !== 40'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", i, all_outs());
      end
    end
`ifdef DATA_BANK_CTRL_STATS_EN
    checks++;
    if (commit_total !== 32'd0) begin
      errors++;
      $display("FAIL reset_commit_total: got %0d want 0", commit_total);
    end
`endif
    idle_inputs();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b ld_ready=%b want 0 0", bus.busy, bus.ld_ready);
    end
  endtask

  task automatic test_load_b2b();
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    checks++;
    if (bus.ld_ready !== 1'b1 || bus.busy !== 1'b1 || bus.bank_wr_addr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_enter_load: ld_ready=%b busy=%b wr_addr=%b want 1 1 0",
               bus.ld_ready, bus.busy, bus.bank_wr_addr);
    end
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hA0 + 32'(i);
      step();
      checks++;
      if (bus.bank_wr_addr !== 1'b1 || bus.bank_wr_all !== 1'b0 ||
          bus.bank_addr !== 2'(i) || bus.bank_data !== 32'hA0 + 32'(i) || bus.ld_done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_write %0d: wr_addr=%b wr_all=%b addr=%0d data=%h done=%b want 1 0 %0d %h 0",
                 i, bus.bank_wr_addr, bus.bank_wr_all, bus.bank_addr, bus.bank_data, bus.ld_done,
                 i, 32'hA0 + 32'(i));
      end
    end
    bus.ld_valid = 1'b0;
    step();
    checks++;
    if (bus.ld_done !== 1'b1 || bus.bank_wr_addr !== 1'b0 || bus.ld_ready !== 1'b0 ||
        bus.bank_addr !== 2'd3 || bus.bank_data !== 32'hA3) begin
      errors++;
      $display("FAIL b2b_ld_done: done=%b wr_addr=%b ready=%b addr=%0d data=%h want 1 0 0 3 a3",
               bus.ld_done, bus.bank_wr_addr, bus.ld_ready, bus.bank_addr, bus.bank_data);
    end
    step();
    checks++;
    if (bus.ld_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_back_idle: done=%b busy=%b want 0 0", bus.ld_done, bus.busy);
    end
  endtask

  task automatic test_load_stall();
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hB0 + 32'(i);
      step();
      bus.ld_valid = 1'b0;
      checks++;
      if (bus.bank_wr_addr !== 1'b1 || bus.bank_addr !== 2'(i) || bus.bank_data !== 32'hB0 + 32'(i)) begin
        errors++;
        $display("FAIL stall_write %0d: wr_addr=%b addr=%0d data=%h want 1 %0d %h",
                 i, bus.bank_wr_addr, bus.bank_addr, bus.bank_data, i, 32'hB0 + 32'(i));
      end
      if (i < 3) begin
        for (int s = 0; s < 3; s++) begin
          step();
          checks++;
          if (bus.bank_wr_addr !== 1'b0 || bus.ld_ready !== 1'b1 || bus.ld_done !== 1'b0 ||
              bus.bank_addr !== 2'(i) || bus.bank_data !== 32'hB0 + 32'(i)) begin
            errors++;
            $display("FAIL stall_hold %0d.%0d: wr_addr=%b ready=%b done=%b addr=%0d data=%h want 0 1 0 %0d %h",
                     i, s, bus.bank_wr_addr, bus.ld_ready, bus.ld_done, bus.bank_addr, bus.bank_data,
                     i, 32'hB0 + 32'(i));
          end
        end
      end
    end
    step();
    checks++;
    if (bus.ld_done !== 1'b1 || bus.bank_wr_addr !== 1'b0) begin
      errors++;
      $display("FAIL stall_ld_done: done=%b wr_addr=%b want 1 0", bus.ld_done, bus.bank_wr_addr);
    end
    step();
  endtask

  task automatic test_run();
    logic exp_all, exp_done, exp_busy;
    bus.run_count = 16'd3;
    bus.run_start = 1'b1;
    step();
    bus.run_start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.bank_wr_all !== 1'b0) begin
      errors++;
      $display("FAIL run_start: busy=%b wr_all=%b want 1 0", bus.busy, bus.bank_wr_all);
    end
    for (int c = 1; c <= 18; c++) begin
      step();
      exp_all  = (c == 5) || (c == 10) || (c == 15);
      exp_done = (c == 16);
      exp_busy = (c < 16);
      checks++;
      if (bus.bank_wr_all !== exp_all || bus.run_done !== exp_done || bus.busy !== exp_busy ||
          bus.bank_wr_addr !== 1'b0) begin
        errors++;
        $display("FAIL run_cycle %0d: wr_all=%b done=%b busy=%b wr_addr=%b want %b %b %b 0",
                 c, bus.bank_wr_all, bus.run_done, bus.busy, bus.bank_wr_addr,
                 exp_all, exp_done, exp_busy);
      end
    end
  endtask

  task automatic test_run_zero();
    bus.run_count = 16'd0;
    bus.run_start = 1'b1;
    step();
    bus.run_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (bus.bank_wr_all !== 1'b0 || bus.run_done !== (c == 1)) begin
        errors++;
        $display("FAIL run_zero cycle %0d: wr_all=%b done=%b want 0 %b",
                 c, bus.bank_wr_all, bus.run_done, (c == 1));
      end
    end
  endtask

  task automatic test_contention();
    logic saw_run;
    bus.ld_start  = 1'b1;
    bus.run_start = 1'b1;
    bus.run_count = 16'd2;
    step();
    bus.ld_start  = 1'b0;
    bus.run_start = 1'b0;
    checks++;
    if (bus.ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL contention_load_wins: ld_ready=%b want 1", bus.ld_ready);
    end
    bus.run_start = 1'b1;
    step();
    bus.run_start = 1'b0;
    checks++;
    if (bus.ld_ready !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL contention_run_in_load: ld_ready=%b busy=%b want 1 1", bus.ld_ready, bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hC0 + 32'(i);
      step();
      checks++;
      if (bus.bank_wr_addr !== 1'b1 || bus.bank_addr !== 2'(i) || bus.bank_data !== 32'hC0 + 32'(i)) begin
        errors++;
        $display("FAIL contention_write %0d: wr_addr=%b addr=%0d data=%h want 1 %0d %h",
                 i, bus.bank_wr_addr, bus.bank_addr, bus.bank_data, i, 32'hC0 + 32'(i));
      end
    end
    bus.ld_valid = 1'b0;
    step();
    checks++;
    if (bus.ld_done !== 1'b1) begin
      errors++;
      $display("FAIL contention_ld_done: got %b want 1", bus.ld_done);
    end
    saw_run = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.bank_wr_all === 1'b1 || bus.run_done === 1'b1 || bus.busy === 1'b1) saw_run = 1'b1;
    end
    checks++;
    if (saw_run !== 1'b0) begin
      errors++;
      $display("FAIL contention_no_run: saw run activity=%b want 0", saw_run);
    end
  endtask

  task automatic test_abort();
    logic [31:0] total_before;
`ifdef DATA_BANK_CTRL_STATS_EN
    total_before = commit_total;
`else
    total_before = 32'd0;
`endif
    bus.run_abort = 1'b1;
    step();
    bus.run_abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.run_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stray_idle: busy=%b done=%b want 0 0", bus.busy, bus.run_done);
    end
    bus.run_count = 16'd5;
    bus.run_start = 1'b1;
    step();
    bus.run_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      bus.run_abort = (c == 7);
      step();
      checks++;
      if (bus.bank_wr_all !== (c == 5) || bus.run_done !== (c == 8)) begin
        errors++;
        $display("FAIL abort_cycle %0d: wr_all=%b done=%b want %b %b",
                 c, bus.bank_wr_all, bus.run_done, (c == 5), (c == 8));
      end
    end
    bus.run_abort = 1'b0;
`ifdef DATA_BANK_CTRL_STATS_EN
    checks++;
    if (commit_total !== total_before + 32'd1) begin
      errors++;
      $display("FAIL abort_commit_total: got %0d want %0d", commit_total, total_before + 32'd1);
    end
`else
    total_before = total_before + 32'd1;
`endif
  endtask

  task automatic test_reset_mid();
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hD0;
    step();
    bus.ld_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 40'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: got %h want 0", all_outs());
    end
    step();
    rst_n = 1'b1;
    step();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hE0;
    step();
    bus.ld_valid = 1'b0;
    checks++;
    if (bus.bank_wr_addr !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abandoned: wr_addr=%b busy=%b want 0 0", bus.bank_wr_addr, bus.busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    test_reset();
    test_load_b2b();
    test_load_stall();
    test_run();
    test_run_zero();
    test_contention();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
